store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the processor's memory stage and the data write port of the unified memory file.
- Accepts word-aligned stores (address, data, byte mask) in one cycle and drains them to memory one per cycle while the port is free.
- Loads can forward bytes from pending stores, so the pipeline never stalls on a store unless the buffer is full.
- Sits directly downstream of the memory stage's write interface (wdata/wmask/word address) and upstream of the memory file write port.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
ADDR_W, 30, word-address width (byte address bits [31:2])
DATA_W, 32, data width; mask width is DATA_W/8

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
st_valid  input  1  store request from memory stage
st_addr  input  ADDR_W  store word address
st_data  input  DATA_W  store data, byte-lane aligned
st_mask  input  DATA_W/8  store byte enables
st_ready  output  1  store accepted this cycle when st_valid && st_ready
ld_valid  input  1  load lookup request
ld_addr  input  ADDR_W  load word address
fwd_mask  output  DATA_W/8  byte lanes supplied by buffer (0 when !ld_valid)
fwd_data  output  DATA_W  forwarded bytes; lanes outside fwd_mask are 0
drain  input  1  block new stores until empty (used before dump)
empty  output  1  no pending entries
count  output  $clog2(DEPTH+1)  pending entry count
mem_busy  input  1  memory write port unavailable this cycle
mem_we  output  1  write strobe to memory file
mem_waddr  output  ADDR_W  head entry address
mem_wdata  output  DATA_W  head entry data
mem_wmask  output  DATA_W/8  head entry mask

Behaviour:
- Storage: circular FIFO of {addr, data, mask}; head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Reset: head=tail=0, count=0, empty=1, mem_we=0, st_ready=1, fwd_mask=0. Reset mid-drain discards all entries; no further mem_we.
- Pop: pop = (count!=0) && !mem_busy. mem_we = pop. mem_waddr/wdata/wmask driven from head entry (registered state, no input-to-output path). On pop the head advances at the clock edge.
- Push readiness: st_ready = !drain && (count<DEPTH || pop). When full, a push is accepted only in a cycle that also pops; count is unchanged.
- Coalescing: if st_valid && st_ready, count!=0, st_addr equals the newest (tail-1) entry, and that entry is not being popped this cycle (count>1 || !pop), merge into it. For each lane with st_mask set, data is replaced and the mask bit is set. No allocation occurs and count is unchanged. Otherwise allocate at tail, advance tail, count+1 (net 0 if popping).
- A store with st_mask==0 is accepted and discarded; no allocation.
- Forwarding (combinational): per byte lane, select the newest valid entry with addr==ld_addr and that lane's mask bit set.
  - fwd_mask sets the lanes found; fwd_data carries those bytes.
  - An entry being popped this cycle still forwards.
  - A store presented in the same cycle is not forwarded. st_valid and ld_valid are never both high; the bench asserts this.
- drain: while high, st_ready=0 and popping continues; empty rises the cycle after the last pop.
- mem_busy held high: buffer holds contents, stores accepted until full, then st_ready=0.

Decomposition:
- Shared package: sb_entry_t struct {addr, data, mask}, DEPTH/width constants, lane count DATA_W/8.
- One natural sub-module: sb_fwd_mux, the per-lane newest-match priority selector across DEPTH entries, ordered from the head pointer.

Test Plan:
- Reset, then st 0x10/0xAABBCCDD/1111 with mem_busy=0 -> next cycle mem_we=1, waddr=0x10, wdata=0xAABBCCDD, wmask=1111; count back to 0 the following cycle.
- mem_busy=1, 5 stores to distinct addrs, DEPTH=4 -> first 4 accepted, st_ready=0 on the 5th, count=4. Release busy -> 5th accepted in the same cycle as the first pop; drain order is FIFO.
- mem_busy=1, st 0x20 data 0x000000EE mask 0001, then st 0x20 data 0x00DD0000 mask 0100 -> count=1; drained entry has wdata=0x00DD00EE and wmask=0101.
- Pending entries 0x30 mask 0011 data 0x1111 (older) and 0x30 mask 0001 data 0x22 (newer, non-adjacent via intervening 0x34 store); ld 0x30 -> fwd_mask=0011, fwd_data=0x00001122.
- mem_busy=1, 3 entries, drain=1 with st_valid=1 -> st_ready=0. Release busy -> 3 consecutive mem_we; empty=1 one cycle after the last.
- rst asserted with count=3 mid-drain -> next cycle count=0, mem_we=0, empty=1; a subsequent load returns fwd_mask=0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer.
// The entry struct is sized from these constants, so the top-level width parameters must match them.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 30;
  localparam int SB_DATA_W = 32;
  localparam int SB_LANES  = SB_DATA_W / 8;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_LANES-1:0]  mask;
  } sb_entry_t;

  // Byte-lane merge: lanes enabled in sel take the new data, the rest keep the old data.
  function automatic logic [SB_DATA_W-1:0] lane_merge(
    input logic [SB_DATA_W-1:0] old_data,
    input logic [SB_DATA_W-1:0] new_data,
    input logic [SB_LANES-1:0]  sel
  );
    logic [SB_DATA_W-1:0] res;
    res = old_data;
    for (int l = 0; l < SB_LANES; l++) begin
      if (sel[l]) res[8*l +: 8] = new_data[8*l +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_fwd_mux.sv
// Per-lane store-to-load forwarding selector: the newest pending entry that matches the
// load address and has the lane enabled supplies that byte.
module sb_fwd_mux
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                    i_entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  input  logic [$clog2(DEPTH+1)-1:0]   i_count,
  input  logic                         i_ld_valid,
  input  logic [SB_ADDR_W-1:0]         i_ld_addr,
  output logic [SB_LANES-1:0]          o_fwd_mask,
  output logic [SB_DATA_W-1:0]         o_fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] w_idx;
  logic          w_hit;

  // Walk oldest to newest from the head so later matches overwrite earlier ones.
  always_comb begin
    o_fwd_mask = '0;
    o_fwd_data = '0;
    w_idx      = i_head;
    w_hit      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      w_hit = i_ld_valid && (CW'(k) < i_count) && (i_entries[w_idx].addr == i_ld_addr);
      for (int l = 0; l < SB_LANES; l++) begin
        if (w_hit && i_entries[w_idx].mask[l]) begin
          o_fwd_mask[l]         = 1'b1;
          o_fwd_data[8*l +: 8]  = i_entries[w_idx].data[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: circular FIFO of word stores with tail coalescing,
// one drain write per free memory cycle, and byte forwarding to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        st_valid,
  input  logic [ADDR_W-1:0]           st_addr,
  input  logic [DATA_W-1:0]           st_data,
  input  logic [DATA_W/8-1:0]         st_mask,
  output logic                        st_ready,
  input  logic                        ld_valid,
  input  logic [ADDR_W-1:0]           ld_addr,
  output logic [DATA_W/8-1:0]         fwd_mask,
  output logic [DATA_W-1:0]           fwd_data,
  input  logic                        drain,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  input  logic                        mem_busy,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_waddr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W/8-1:0]         mem_wmask
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  sb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_coalesce;
  logic          w_alloc;
  logic [PW-1:0] w_newest;
  sb_entry_t     w_head_ent;

  assign w_pop      = (r_count != '0) && !mem_busy;
  assign st_ready   = !drain && ((r_count != FULL) || w_pop);
  // Empty-mask stores are acknowledged but never occupy an entry.
  assign w_push     = st_valid && st_ready && (st_mask != '0);
  assign w_newest   = r_tail - PW'(1);
  // The newest entry may only absorb a store if it is not leaving this cycle.
  assign w_coalesce = w_push && (r_count != '0) && (r_mem[w_newest].addr == st_addr) &&
                      ((r_count > CW'(1)) || !w_pop);
  assign w_alloc    = w_push && !w_coalesce;

  assign w_head_ent = r_mem[r_head];
  assign mem_we     = w_pop;
  assign mem_waddr  = w_head_ent.addr;
  assign mem_wdata  = w_head_ent.data;
  assign mem_wmask  = w_head_ent.mask;
  assign empty      = (r_count == '0);
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)   r_head <= r_head + PW'(1);
      if (w_alloc) r_tail <= r_tail + PW'(1);
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_mem[r_tail] <= '{addr: st_addr, data: st_data, mask: st_mask};
    end else if (w_coalesce) begin
      r_mem[w_newest] <= '{addr: r_mem[w_newest].addr,
                           data: lane_merge(r_mem[w_newest].data, st_data, st_mask),
                           mask: r_mem[w_newest].mask | st_mask};
    end
  end

  sb_fwd_mux #(
    .DEPTH(DEPTH)
  ) u_fwd_mux (
    .i_entries  (r_mem),
    .i_head     (r_head),
    .i_count    (r_count),
    .i_ld_valid (ld_valid),
    .i_ld_addr  (ld_addr),
    .o_fwd_mask (fwd_mask),
    .o_fwd_data (fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table for the documented scenarios, then
// random traffic compared against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [29:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        st_ready;
  logic        ld_valid;
  logic [29:0] ld_addr;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic        drain;
  logic        empty;
  logic [2:0]  count;
  logic        mem_busy;
  logic        mem_we;
  logic [29:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(30), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .fwd_mask(fwd_mask), .fwd_data(fwd_data),
    .drain(drain), .empty(empty), .count(count),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(st_valid && ld_valid)) else $error("st_valid and ld_valid both high");
  end

  typedef struct {
    logic        rst, sv;
    logic [29:0] sa;
    logic [31:0] sd;
    logic [3:0]  sm;
    logic        lv;
    logic [29:0] la;
    logic        dr, bz;
    logic        rdy, we;
    logic [29:0] wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [2:0]  cnt;
    logic [3:0]  fm;
    logic [31:0] fd;
  } vec_t;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ment_t;

  vec_t  vecs[$];
  ment_t q[$];

  function automatic vec_t mk(logic r, logic sv, logic [29:0] sa, logic [31:0] sd, logic [3:0] sm,
                              logic lv, logic [29:0] la, logic dr, logic bz,
                              logic rdy, logic we, logic [29:0] wa, logic [31:0] wd, logic [3:0] wm,
                              logic [2:0] cnt, logic [3:0] fm, logic [31:0] fd);
    vec_t v;
    v.rst = r; v.sv = sv; v.sa = sa; v.sd = sd; v.sm = sm; v.lv = lv; v.la = la;
    v.dr = dr; v.bz = bz; v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd; v.wm = wm;
    v.cnt = cnt; v.fm = fm; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic sv, input logic [29:0] sa, input logic [31:0] sd,
                       input logic [3:0] sm, input logic lv, input logic [29:0] la,
                       input logic dr, input logic bz);
    rst = r; st_valid = sv; st_addr = sa; st_data = sd; st_mask = sm;
    ld_valid = lv; ld_addr = la; drain = dr; mem_busy = bz;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic we, input logic [29:0] wa,
                            input logic [31:0] wd, input logic [3:0] wm, input logic [2:0] cnt,
                            input logic [3:0] fm, input logic [31:0] fd);
    chk({tag, " st_ready"}, 32'(st_ready), 32'(rdy));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
    if (we) begin
      chk({tag, " mem_waddr"}, 32'(mem_waddr), 32'(wa));
      chk({tag, " mem_wdata"}, mem_wdata, wd);
      chk({tag, " mem_wmask"}, 32'(mem_wmask), 32'(wm));
    end
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " empty"}, 32'(empty), 32'(cnt == 3'd0));
    chk({tag, " fwd_mask"}, 32'(fwd_mask), 32'(fm));
    chk({tag, " fwd_data"}, fwd_data, fd);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;

    // basic store and single drain
    vecs.push_back(mk(0,0,0,0,0, 1,'h10, 0,0, 1,0,0,0,0, 0, 0,0));
    vecs.push_back(mk(0,1,'h10,'hAABBCCDD,'hF, 0,0, 0,0, 1,0,0,0,0, 0, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,1,'h10,'hAABBCCDD,'hF, 1, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,0,0,0,0, 0, 0,0));
    // fill under busy, fifth blocked, then accepted alongside first pop
    vecs.push_back(mk(0,1,'h40,'h10000000,'hF, 0,0, 0,1, 1,0,0,0,0, 0, 0,0));
    vecs.push_back(mk(0,1,'h41,'h10000001,'hF, 0,0, 0,1, 1,0,0,0,0, 1, 0,0));
    vecs.push_back(mk(0,1,'h42,'h10000002,'hF, 0,0, 0,1, 1,0,0,0,0, 2, 0,0));
    vecs.push_back(mk(0,1,'h43,'h10000003,'hF, 0,0, 0,1, 1,0,0,0,0, 3, 0,0));
    vecs.push_back(mk(0,1,'h44,'h10000004,'hF, 0,0, 0,1, 0,0,0,0,0, 4, 0,0));
    vecs.push_back(mk(0,1,'h44,'h10000004,'hF, 0,0, 0,0, 1,1,'h40,'h10000000,'hF, 4, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,1,'h41,'h10000001,'hF, 4, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,1,'h42,'h10000002,'hF, 3, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,1,'h43,'h10000003,'hF, 2, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,1,'h44,'h10000004,'hF, 1, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,0,0,0,0, 0, 0,0));
    // coalescing into the newest entry
    vecs.push_back(mk(0,1,'h20,'h000000EE,'h1, 0,0, 0,1, 1,0,0,0,0, 0, 0,0));
    vecs.push_back(mk(0,1,'h20,'h00DD0000,'h4, 0,0, 0,1, 1,0,0,0,0, 1, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,'h20, 0,1, 1,0,0,0,0, 1, 'h5,'h00DD00EE));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,1,'h20,'h00DD00EE,'h5, 1, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 0,0, 1,0,0,0,0, 0, 0,0));
    // per-lane newest-match forwarding across a non-adjacent pair
    vecs.push_back(mk(0,1,'h30,'h00001111,'h3, 0,0, 0,1, 1,0,0,0,0, 0, 0,0));
    vecs.push_back(mk(0,1,'h34,'h55555555,'hF, 0,0, 0,1, 1,0,0,0,0, 1, 0,0));
    vecs.push_back(mk(0,1,'h30,'h00000022,'h1, 0,0, 0,1, 1,0,0,0,0, 2, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,'h30, 0,1, 1,0,0,0,0, 3, 'h3,'h00001122));
    // drain blocks stores and empties the buffer in order
    vecs.push_back(mk(0,1,'h50,'h12345678,'hF, 0,0, 1,1, 0,0,0,0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 1,0, 0,1,'h30,'h00001111,'h3, 3, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 1,0, 0,1,'h34,'h55555555,'hF, 2, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 1,0, 0,1,'h30,'h00000022,'h1, 1, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 1,0, 0,0,0,0,0, 0, 0,0));
    // reset while draining discards everything
    vecs.push_back(mk(0,1,'h60,'h00000001,'hF, 0,0, 0,1, 1,0,0,0,0, 0, 0,0));
    vecs.push_back(mk(0,1,'h61,'h00000002,'hF, 0,0, 0,1, 1,0,0,0,0, 1, 0,0));
    vecs.push_back(mk(0,1,'h62,'h00000003,'hF, 0,0, 0,1, 1,0,0,0,0, 2, 0,0));
    vecs.push_back(mk(0,1,'h63,'h00000004,'hF, 0,0, 0,1, 1,0,0,0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0, 1,0, 0,1,'h60,'h00000001,'hF, 4, 0,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0, 1,1, 0,0,0,0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,'h60, 1,0, 0,0,0,0,0, 0, 0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,'h61, 0,0, 1,0,0,0,0, 0, 0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].sm,
            vecs[i].lv, vecs[i].la, vecs[i].dr, vecs[i].bz);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].wa, vecs[i].wd,
                 vecs[i].wm, vecs[i].cnt, vecs[i].fm, vecs[i].fd);
      @(posedge clk); #1;
    end

    // random traffic against the reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        r, sv, lv, dr, bz, mpop, mrdy, merged;
      logic [29:0] sa, la;
      logic [31:0] sd, efd;
      logic [3:0]  sm, efm;
      int          op;
      r  = ($urandom_range(0, 199) == 0);
      bz = ($urandom_range(0, 2) == 0);
      dr = ($urandom_range(0, 11) == 0);
      op = int'($urandom_range(0, 2));
      sv = (op == 0);
      lv = (op == 1);
      sa = 30'h70 + 30'($urandom_range(0, 3));
      la = 30'h70 + 30'($urandom_range(0, 3));
      sd = $urandom;
      sm = 4'($urandom_range(0, 15));
      drive(r, sv, sa, sd, sm, lv, la, dr, bz);

      mpop = (q.size() != 0) && !bz;
      mrdy = !dr && ((q.size() < DEPTH) || mpop);
      efm = '0;
      efd = '0;
      if (lv) begin
        for (int l = 0; l < 4; l++) begin
          for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].addr == la && q[k].mask[l]) begin
              efm[l] = 1'b1;
              efd[8*l +: 8] = q[k].data[8*l +: 8];
              break;
            end
          end
        end
      end
      #2;
      if (q.size() != 0)
        check_outs($sformatf("rnd%0d", c), mrdy, mpop, q[0].addr, q[0].data, q[0].mask,
                   3'(q.size()), efm, efd);
      else
        check_outs($sformatf("rnd%0d", c), mrdy, 1'b0, '0, '0, '0, 3'd0, efm, efd);
      @(posedge clk);

      if (r) begin
        q.delete();
      end else begin
        if (sv && mrdy && sm != 4'd0) begin
          merged = 1'b0;
          if (q.size() != 0 && q[q.size()-1].addr == sa && !(mpop && q.size() == 1)) begin
            for (int l = 0; l < 4; l++)
              if (sm[l]) q[q.size()-1].data[8*l +: 8] = sd[8*l +: 8];
            q[q.size()-1].mask = q[q.size()-1].mask | sm;
            merged = 1'b1;
          end
          if (!merged) q.push_back('{addr: sa, data: sd, mask: sm});
        end
        if (mpop) void'(q.pop_front());
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
